// File: rtl/pole_phase_scanner_if.sv
// rtl/pole_phase_scanner_if.sv - pixel stream, handshake and pole inputs of the pole phase scanner
interface pole_phase_scanner_if;
  logic               ready;
  logic signed [15:0] pole_re;
  logic signed [15:0] pole_im;
  logic               valid;
  logic signed [15:0] x;
  logic signed [15:0] y;
  logic signed [15:0] diff_re;
  logic signed [15:0] diff_im;
  logic        [15:0] phase;
  logic               first;
  logic               lastx;

  modport master (
    input  ready, pole_re, pole_im,
    output valid, x, y, diff_re, diff_im, phase, first, lastx
  );

  modport slave (
    output ready, pole_re, pole_im,
    input  valid, x, y, diff_re, diff_im, phase, first, lastx
  );
endinterface

// File: rtl/pole_phase_scanner.sv
// rtl/pole_phase_scanner.sv - raster scanner returning the phase of each pixel relative to a per-frame pole
module pole_phase_scanner #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  pole_phase_scanner_if.master io
);

  localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
  localparam logic [15:0] HALF_W   = 16'(WIDTH / 2);
  localparam logic [15:0] HALF_H   = 16'(HEIGHT / 2);
  localparam real         TWO_PI   = 6.283185307179586;

  logic        [15:0] r_col;
  logic        [15:0] r_row;
  logic               r_valid;
  logic signed [15:0] r_pr;
  logic signed [15:0] r_pi;

  logic               w_first;
  logic               w_lastx;
  logic               w_lastrow;
  logic signed [15:0] w_x;
  logic signed [15:0] w_y;
  logic signed [16:0] w_dre_raw;
  logic signed [16:0] w_dim_raw;
  logic signed [15:0] w_dre;
  logic signed [15:0] w_dim;
  logic        [16:0] w_a;
  logic        [16:0] w_b;
  logic        [16:0] w_mn;
  logic        [16:0] w_mx;
  logic        [17:0] w_rem;
  logic        [8:0]  w_k;
  logic        [13:0] w_lut [0:256];
  logic        [13:0] w_t;
  logic        [14:0] w_base;
  logic        [15:0] w_phase;

  // Clamp a 17-bit difference into the signed 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? 16'sh8000 : 16'sh7fff;
    end
    return v[15:0];
  endfunction

  // Magnitude in 17 bits so that -32768 maps to 32768 without overflow.
  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic [16:0] e;
    e = {v[15], v};
    return v[15] ? (17'd0 - e) : e;
  endfunction

  // Raster position and output-valid: advance only when the current pixel is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b1;
      if (r_valid && io.ready) begin
        if (w_lastx) begin
          r_col <= '0;
          r_row <= w_lastrow ? 16'd0 : r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
    end
  end

  // Pole is resampled on every edge spent at pixel (0,0), so one value covers a whole frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pr <= '0;
      r_pi <= '0;
    end else if (w_first) begin
      r_pr <= io.pole_re;
      r_pi <= io.pole_im;
    end
  end

  assign w_first   = (r_col == 16'd0) && (r_row == 16'd0);
  assign w_lastx   = (r_col == LAST_COL);
  assign w_lastrow = (r_row == LAST_ROW);

  // Screen coordinates: origin at the grid centre, +y pointing up.
  assign w_x = $signed(r_col - HALF_W);
  assign w_y = $signed(HALF_H - r_row);

  assign w_dre_raw = {w_x[15], w_x} - {r_pr[15], r_pr};
  assign w_dim_raw = {w_y[15], w_y} - {r_pi[15], r_pi};
  assign w_dre     = sat16(w_dre_raw);
  assign w_dim     = sat16(w_dim_raw);

  // Octant reduction: the ratio min/max is always in [0, 1].
  assign w_a  = abs17(w_dre);
  assign w_b  = abs17(w_dim);
  assign w_mn = (w_a >= w_b) ? w_b : w_a;
  assign w_mx = (w_a >= w_b) ? w_a : w_b;

  // Restoring long division producing floor(mn*256/mx); bit 8 is set only when mn == mx.
  always_comb begin
    w_k   = '0;
    w_rem = {1'b0, w_mn};
    if (w_rem >= {1'b0, w_mx}) begin
      w_k[8] = 1'b1;
      w_rem  = w_rem - {1'b0, w_mx};
    end
    for (int i = 7; i >= 0; i--) begin
      w_rem = {w_rem[16:0], 1'b0};
      if (w_rem >= {1'b0, w_mx}) begin
        w_k[i] = 1'b1;
        w_rem  = w_rem - {1'b0, w_mx};
      end
    end
    if (w_mx == 17'd0) begin
      w_k = '0;
    end
  end

  // First-octant arctangent table, atan(k/256) in units of 1/65536 turn.
  for (genvar g = 0; g <= 256; g++) begin : g_lut
    localparam int LV = int'($atan(real'(g) / 256.0) * 65536.0 / TWO_PI);
    assign w_lut[g] = 14'(LV);
  end

  assign w_t    = w_lut[w_k];
  assign w_base = (w_a >= w_b) ? {1'b0, w_t} : (15'd16384 - {1'b0, w_t});

  // Unfold the octant angle into the quadrant given by the signs; 16-bit wrap gives mod 65536.
  always_comb begin
    case ({w_dre[15], w_dim[15]})
      2'b00:   w_phase = {1'b0, w_base};
      2'b10:   w_phase = 16'd32768 - {1'b0, w_base};
      2'b11:   w_phase = 16'd32768 + {1'b0, w_base};
      default: w_phase = 16'd0 - {1'b0, w_base};
    endcase
    if (w_mx == 17'd0) begin
      w_phase = 16'd0;
    end
  end

  assign io.valid   = r_valid;
  assign io.x       = w_x;
  assign io.y       = w_y;
  assign io.diff_re = w_dre;
  assign io.diff_im = w_dim;
  assign io.phase   = w_phase;
  assign io.first   = w_first;
  assign io.lastx   = w_lastx;

endmodule

// File: tb/tb_pole_phase_scanner.sv
// tb/tb_pole_phase_scanner.sv - randomized self-checking bench for pole_phase_scanner
`timescale 1ns/1ps
module tb_pole_phase_scanner;

  localparam int  BW     = 640;
  localparam int  BH     = 480;
  localparam int  SW     = 32;
  localparam int  SH     = 24;
  localparam real TWO_PI = 6.283185307179586;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               rdy [2];
  logic signed [15:0] pre [2];
  logic signed [15:0] pim [2];

  pole_phase_scanner_if bif ();
  pole_phase_scanner_if sif ();

  assign bif.ready   = rdy[0];
  assign bif.pole_re = pre[0];
  assign bif.pole_im = pim[0];
  assign sif.ready   = rdy[1];
  assign sif.pole_re = pre[1];
  assign sif.pole_im = pim[1];

  pole_phase_scanner #(.WIDTH(BW), .HEIGHT(BH)) u_big (
    .clk   (clk),
    .reset (reset),
    .io    (bif.master)
  );

  pole_phase_scanner #(.WIDTH(SW), .HEIGHT(SH)) u_small (
    .clk   (clk),
    .reset (reset),
    .io    (sif.master)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: raster position, valid, latched pole and accept count per instance.
  int m_col [2];
  int m_row [2];
  int m_pr  [2];
  int m_pi  [2];
  int m_acc [2];
  bit m_valid [2];
  int mw [2] = '{BW, SW};
  int mh [2] = '{BH, SH};

  int dp_col [5] = '{16, 0, 6, 16, 16};
  int dp_row [5] = '{0, 12, 22, 23, 12};
  int dp_ph  [5] = '{16384, 32768, 40960, 49152, 0};

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int d;
    int err;
    bit ok;
    n_total++;
    if (tol == 0) begin
      ok = (got == exp);
    end else begin
      d   = (((got - exp) % 65536) + 65536) % 65536;
      err = (d > 32768) ? 65536 - d : d;
      ok  = (err <= tol);
    end
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, got, exp, tol);
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int ref_phase(input int dr, input int di);
    real p;
    int  r;
    if (dr == 0 && di == 0) return 0;
    p = $atan2(real'(di), real'(dr)) * 65536.0 / TWO_PI;
    if (p < 0.0) p = p + 65536.0;
    r = int'(p);
    return r % 65536;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_col[d]   = 0;
      m_row[d]   = 0;
      m_pr[d]    = 0;
      m_pi[d]    = 0;
      m_valid[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_col[d] = 0; m_row[d] = 0; m_pr[d] = 0; m_pi[d] = 0; m_valid[d] = 1'b0;
      end else begin
        if (m_col[d] == 0 && m_row[d] == 0) begin
          m_pr[d] = pre[d];
          m_pi[d] = pim[d];
        end
        if (m_valid[d] && rdy[d]) begin
          m_acc[d]++;
          m_col[d]++;
          if (m_col[d] == mw[d]) begin
            m_col[d] = 0;
            m_row[d] = (m_row[d] + 1) % mh[d];
          end
        end
        m_valid[d] = 1'b1;
      end
    end
  endtask

  task automatic compare_dut(input int d);
    int ax, ay, adr, adi, aph, av, af, al;
    int ex, ey, edr, edi;
    string nm;
    if (d == 0) begin
      nm = "big";
      ax = bif.x; ay = bif.y; adr = bif.diff_re; adi = bif.diff_im;
      aph = bif.phase; av = bif.valid; af = bif.first; al = bif.lastx;
    end else begin
      nm = "small";
      ax = sif.x; ay = sif.y; adr = sif.diff_re; adi = sif.diff_im;
      aph = sif.phase; av = sif.valid; af = sif.first; al = sif.lastx;
    end
    ex  = m_col[d] - mw[d] / 2;
    ey  = mh[d] / 2 - m_row[d];
    edr = sat(ex - m_pr[d]);
    edi = sat(ey - m_pi[d]);
    check({nm, ".valid"},   av,  int'(m_valid[d]), 0);
    check({nm, ".x"},       ax,  ex, 0);
    check({nm, ".y"},       ay,  ey, 0);
    check({nm, ".first"},   af,  int'(m_col[d] == 0 && m_row[d] == 0), 0);
    check({nm, ".lastx"},   al,  int'(m_col[d] == mw[d] - 1), 0);
    check({nm, ".diff_re"}, adr, edr, 0);
    check({nm, ".diff_im"}, adi, edi, 0);
    check({nm, ".phase"},   aph, ref_phase(edr, edi), 48);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_dut(0);
    compare_dut(1);
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_dut(0);
    compare_dut(1);
  endtask

  task automatic run_small(input int accepts, input int max_cycles, input bit dir_en, input int change_at);
    int start;
    int c;
    start = m_acc[1];
    c     = 0;
    while ((m_acc[1] - start) < accepts && c < max_cycles) begin
      rdy[1] = ($urandom_range(0, 3) != 0);
      if (change_at >= 0 && (m_acc[1] - start) == change_at) begin
        pre[1] = 16'($urandom);
        pim[1] = 16'($urandom);
      end
      cycle();
      c++;
      if (dir_en) begin
        for (int i = 0; i < 5; i++) begin
          if (m_col[1] == dp_col[i] && m_row[1] == dp_row[i]) check("axis_phase", int'(sif.phase), dp_ph[i], 0);
        end
      end
    end
    check("small.sweep_done", m_acc[1] - start, accepts, 0);
    rdy[1] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rdy[d] = 1'b0; pre[d] = '0; pim[d] = '0; m_acc[d] = 0;
    end
    assert_reset();
    @(negedge clk);
    check("rst.valid", int'(bif.valid), 0, 0);
    check("rst.first", int'(bif.first), 1, 0);
    check("rst.x",     int'(bif.x), -320, 0);
    check("rst.y",     int'(bif.y), 240, 0);
    check("rst.lastx", int'(bif.lastx), 0, 0);
    check("rst.small_x", int'(sif.x), -16, 0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("rel.valid", int'(bif.valid), 1, 0);
    repeat (5) begin
      cycle();
      check("stall.x", int'(bif.x), -320, 0);
      check("stall.y", int'(bif.y), 240, 0);
    end

    rdy[0] = 1'b1;
    repeat (319) cycle();
    check("acc319.x", int'(bif.x), -1, 0);
    check("acc319.y", int'(bif.y), 240, 0);
    repeat (320) cycle();
    check("acc639.lastx", int'(bif.lastx), 1, 0);
    cycle();
    check("acc640.x", int'(bif.x), -320, 0);
    check("acc640.y", int'(bif.y), 239, 0);
    check("acc640.lastx", int'(bif.lastx), 0, 0);
    rdy[0] = 1'b0;

    run_small(SW * SH, 5000, 1'b1, -1);
    check("wrap.first", int'(sif.first), 1, 0);
    check("wrap.y", int'(sif.y), 12, 0);

    pre[1] = 16'sd37;
    pim[1] = -16'sd91;
    run_small(SW * SH, 5000, 1'b0, 300);
    run_small(200, 1000, 1'b0, 100);

    @(negedge clk);
    assert_reset();
    pre[0] = 16'sd10;
    pim[0] = -16'sd5;
    cycle();
    reset  = 1'b0;
    rdy[0] = 1'b1;
    repeat (100) cycle();
    pre[0] = 16'($urandom);
    pim[0] = 16'($urandom);
    repeat (400) cycle();
    check("pole10.diff_re", int'(bif.diff_re), (m_col[0] - 320) - 10, 0);
    check("pole10.diff_im", int'(bif.diff_im), (240 - m_row[0]) + 5, 0);
    rdy[0] = 1'b0;

    assert_reset();
    pre[0] = 16'sh7fff;
    pim[0] = 16'sh8000;
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    check("sat.diff_re", int'(bif.diff_re), -32768, 0);
    check("sat.diff_im", int'(bif.diff_im), 32767, 0);
    check("sat.phase",   int'(bif.phase), 24576, 48);

    pre[1] = '0;
    pim[1] = '0;
    run_small(100, 1000, 1'b0, -1);
    assert_reset();
    check("midrst.first", int'(sif.first), 1, 0);
    check("midrst.x",     int'(sif.x), -16, 0);
    check("midrst.valid", int'(sif.valid), 0, 0);
    cycle();
    reset = 1'b0;
    cycle();
    check("midrst.revalid", int'(sif.valid), 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
